// File: rtl/sanity_keepalive_if.sv
// Keep-alive control/status bundle between host-side logic and sanity_keepalive.
// Latency: none, plain wires.
// Backpressure: none; the heartbeat is a one-tick strobe and status is level-valued.
interface sanity_keepalive_if #(
  parameter int KCW = 8
) ();

  // Host -> scheduler
  logic [2:0]     sanity;      // timeout code; [1:0] selects 1/4/16/64 ticks, [2] selects tick rate
  logic           ena_req;     // software enable for sanity supervision
  logic           alive;       // heartbeat strobe, one sanity_clk tick wide

  // Scheduler -> timer / host
  logic           tim_ena;     // sanity timer enable; low holds the timer in restart
  logic           warn;        // expiry imminent
  logic           expired;     // sticky timeout flag
  logic [KCW-1:0] kick_count;  // restarts issued since leaving OFF
  logic [6:0]     remaining;   // mirrored ticks left before the timer fires

  modport master (
    output sanity, ena_req, alive,
    input  tim_ena, warn, expired, kick_count, remaining
  );

  modport slave (
    input  sanity, ena_req, alive,
    output tim_ena, warn, expired, kick_count, remaining
  );

endinterface

// File: rtl/sanity_keepalive.sv
// Turns host heartbeats into sanity-timer restart pulses and mirrors the countdown.
// Latency: every output is registered, one sanity_clk after the inputs that cause it.
// Backpressure: none; heartbeats arriving while a restart is in progress are dropped.
module sanity_keepalive #(
  parameter int MARGIN        = 1,  // warn while remaining <= MARGIN in RUN
  parameter int RESTART_TICKS = 1,  // ticks tim_ena is held low per restart, 1..7
  parameter int KCW           = 8   // kick_count width, saturating
) (
  input  logic             reset,
  input  logic             sanity_clk,
  sanity_keepalive_if.slave bus
);

  // FSM encoding kept as plain constants so it matches the older timer logic.
  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_KICK    = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [6:0]     MARGIN_W = 7'(MARGIN);
  localparam logic [2:0]     RT_W     = 3'(RESTART_TICKS);
  localparam logic [KCW-1:0] KICK_MAX = {KCW{1'b1}};

  // Registered state
  logic [1:0]     state_q, state_d;
  logic [6:0]     n_lim_q, n_lim_d;   // timeout length latched on OFF->RUN
  logic [6:0]     rem_q,   rem_d;
  logic [KCW-1:0] kick_q,  kick_d;
  logic [2:0]     rcnt_q,  rcnt_d;    // ticks left in the current restart pulse
  logic           tim_q,   tim_d;
  logic           warn_q,  warn_d;
  logic           exp_q,   exp_d;

  // Timeout length for the current code; bit 2 only changes the tick rate of
  // sanity_clk itself, so the tick count does not depend on it.
  logic [6:0] n_sel;
  logic       unused_tick_scale;
  assign unused_tick_scale = bus.sanity[2];

  // Decode the timeout code into a tick count.
  always_comb begin
    n_sel = 7'd1;
    case (bus.sanity[1:0])
      2'b00:   n_sel = 7'd1;
      2'b01:   n_sel = 7'd4;
      2'b10:   n_sel = 7'd16;
      default: n_sel = 7'd64;
    endcase
  end

  // Next-state logic; dropping ena_req overrides everything else.
  always_comb begin
    state_d = state_q;
    n_lim_d = n_lim_q;
    rem_d   = rem_q;
    kick_d  = kick_q;
    rcnt_d  = rcnt_q;
    tim_d   = tim_q;
    exp_d   = exp_q;

    if (!bus.ena_req) begin
      // kick_count deliberately survives so software can read it after disabling
      state_d = ST_OFF;
      tim_d   = 1'b0;
      exp_d   = 1'b0;
      rem_d   = 7'd0;
      rcnt_d  = 3'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_RUN;
          n_lim_d = n_sel;
          rem_d   = n_sel;
          kick_d  = '0;
          tim_d   = 1'b1;
          exp_d   = 1'b0;
        end
        ST_RUN: begin
          tim_d = 1'b1;
          // A heartbeat on the last tick still rescues the timer.
          if (bus.alive) begin
            state_d = ST_KICK;
            tim_d   = 1'b0;
            rcnt_d  = RT_W;
            if (kick_q != KICK_MAX) begin
              kick_d = kick_q + KCW'(1);
            end
          end else if (rem_q <= 7'd1) begin
            state_d = ST_EXPIRED;
            rem_d   = 7'd0;
            exp_d   = 1'b1;
          end else begin
            rem_d = rem_q - 7'd1;
          end
        end
        ST_KICK: begin
          // remaining holds its pre-kick value until the timer is released
          tim_d = 1'b0;
          if (rcnt_q <= 3'd1) begin
            state_d = ST_RUN;
            rem_d   = n_lim_q;
            tim_d   = 1'b1;
            rcnt_d  = 3'd0;
          end else begin
            rcnt_d = rcnt_q - 3'd1;
          end
        end
        ST_EXPIRED: begin
          // Timer has fired: let it run, ignore heartbeats until software disables.
          tim_d = 1'b1;
          exp_d = 1'b1;
          rem_d = 7'd0;
        end
        default: begin
          state_d = ST_OFF;
          tim_d   = 1'b0;
          exp_d   = 1'b0;
          rem_d   = 7'd0;
        end
      endcase
    end

    warn_d = (state_d == ST_RUN) && (rem_d <= MARGIN_W);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge sanity_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      n_lim_q <= 7'd0;
      rem_q   <= 7'd0;
      kick_q  <= '0;
      rcnt_q  <= 3'd0;
      tim_q   <= 1'b0;
      warn_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_lim_q <= n_lim_d;
      rem_q   <= rem_d;
      kick_q  <= kick_d;
      rcnt_q  <= rcnt_d;
      tim_q   <= tim_d;
      warn_q  <= warn_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.tim_ena    = tim_q;
  assign bus.warn       = warn_q;
  assign bus.expired    = exp_q;
  assign bus.kick_count = kick_q;
  assign bus.remaining  = rem_q;

endmodule
